// File: rtl/sub_u_pkg.sv
// Shared types and sizing helpers for the bit-serial saturating subtractor.
//   state_t     : FSM encoding (IDLE, RUN, DONE)
//   cnt_width() : bit-counter width for a given operand width
package sub_u_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must index bits 0..W-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_sub_bit.sv
// Combinational 1-bit full subtractor: computes x - y - b_in.
//   x, y  : operand bits
//   b_in  : incoming borrow
//   d     : difference bit
//   b_out : outgoing borrow
module full_sub_bit (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = x ^ y ^ b_in;
  // Borrow when y exceeds x, or when they are equal and a borrow is pending.
  assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/sub_u_serial.sv
// Bit-serial unsigned subtractor, LSB first, saturating at zero.
// One bit per clock through a single borrow flop; start/busy/done handshake.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   start_i : begin a subtraction (accepted while busy_o = 0)
//   x_i     : minuend, sampled on the accepting edge
//   y_i     : subtrahend, sampled on the accepting edge
//   busy_o  : operation in progress
//   done_o  : one-cycle pulse when diff_o/uf_o are updated
//   diff_o  : max(x - y, 0)
//   uf_o    : 1 when x < y
module sub_u_serial
  import sub_u_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] diff_o,
  output logic         uf_o
);

  localparam int unsigned CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   res_q, res_d;
  logic           b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   diff_q, diff_d;
  logic           uf_q, uf_d;

  logic           d_bit;
  logic           b_next;

  // Single bit-slice shared across all W cycles.
  full_sub_bit u_bit (
    .x     (x_q[0]),
    .y     (y_q[0]),
    .b_in  (b_q),
    .d     (d_bit),
    .b_out (b_next)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    uf_d    = uf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          state_d = RUN;
          x_d     = x_i;
          y_d     = y_i;
          res_d   = '0;
          b_d     = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        x_d   = x_q >> 1;
        y_d   = y_q >> 1;
        res_d = {d_bit, res_q[W-1:1]};
        b_d   = b_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          done_d  = 1'b1;
          // A borrow out of the MSB means x < y: clamp to zero.
          if (b_next) begin
            diff_d = '0;
            uf_d   = 1'b1;
          end else begin
            diff_d = res_d;
            uf_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      b_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      uf_q    <= uf_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign diff_o = diff_q;
  assign uf_o   = uf_q;

endmodule

// File: tb/tb_sub_u_serial.sv
// Directed self-checking bench for sub_u_serial (W = 4).
module tb_sub_u_serial;

  localparam int unsigned W = 4;

  logic         clk_i;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] x_i;
  logic [W-1:0] y_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] diff_o;
  logic         uf_o;

  int checks = 0;
  int errors = 0;

  sub_u_serial #(.W(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .x_i     (x_i),
    .y_i     (y_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .diff_o  (diff_o),
    .uf_o    (uf_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present operands with start, then drop start and
  // scramble the operand inputs. Returns at the first negedge after acceptance.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    start_i = 1'b1;
    x_i     = x;
    y_i     = y;
    @(negedge clk_i);
    start_i = 1'b0;
    x_i     = W'($urandom);
    y_i     = W'($urandom);
  endtask

  // Polls done_o at successive negedges (first poll counts as cycle 1).
  task automatic wait_done(output int cyc, output int nbusy, output bit seen);
    cyc   = 1;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && cyc <= int'(W) + 6) begin
      if (done_o) begin
        seen = 1'b1;
      end else begin
        if (busy_o) nbusy++;
        @(negedge clk_i);
        cyc++;
      end
    end
  endtask

  // Full operation with latency/busy checks and bench-side reference result.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    int cyc;
    int nbusy;
    bit seen;
    logic [W-1:0] exp_diff;
    logic         exp_uf;
    exp_uf   = (x < y);
    exp_diff = exp_uf ? '0 : W'(x - y);
    start_op(x, y);
    wait_done(cyc, nbusy, seen);
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"},   32'(cyc), 32'(W + 1));
    chk({tag, "_busy_cyc"},  32'(nbusy), 32'(W));
    chk({tag, "_diff"},      32'(diff_o), 32'(exp_diff));
    chk({tag, "_uf"},        32'(uf_o), 32'(exp_uf));
  endtask

  initial begin
    int cyc;
    int nbusy;
    bit seen;
    int ndone;

    rst_i   = 1'b1;
    start_i = 1'b0;
    x_i     = '0;
    y_i     = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_diff", 32'(diff_o), 32'd0);
    chk("rst_uf",   32'(uf_o),   32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Basic: 9 - 3 = 6
    op(4'd9, 4'd3, "basic");
    @(negedge clk_i);
    chk("basic_done_pulse", 32'(done_o), 32'd0);
    chk("basic_diff_hold",  32'(diff_o), 32'd6);
    chk("basic_idle_busy",  32'(busy_o), 32'd0);

    // Underflow and edge operands
    op(4'd2,  4'd7,  "uf_2_7");   @(negedge clk_i);
    op(4'd15, 4'd15, "eq_15");    @(negedge clk_i);
    op(4'd15, 4'd0,  "max_0");    @(negedge clk_i);
    op(4'd0,  4'd1,  "uf_0_1");   @(negedge clk_i);

    // start during RUN must be ignored
    start_op(4'd12, 4'd4);
    @(negedge clk_i);
    start_i = 1'b1;
    x_i     = 4'd5;
    y_i     = 4'd1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(cyc, nbusy, seen);
    chk("ign_done_seen", 32'(seen),   32'd1);
    chk("ign_diff",      32'(diff_o), 32'd8);
    chk("ign_uf",        32'(uf_o),   32'd0);
    @(negedge clk_i);
    chk("ign_no_restart", 32'(busy_o), 32'd0);
    chk("ign_no_done",    32'(done_o), 32'd0);

    // Back-to-back: start presented in the DONE cycle
    start_op(4'd13, 4'd6);
    wait_done(cyc, nbusy, seen);
    chk("b2b_first_seen", 32'(seen),   32'd1);
    chk("b2b_first_diff", 32'(diff_o), 32'd7);
    chk("b2b_first_busy", 32'(busy_o), 32'd0);
    op(4'd3, 4'd8, "b2b_second");
    @(negedge clk_i);

    // Reset in the second RUN cycle aborts the operation
    start_op(4'd10, 4'd3);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_diff", 32'(diff_o), 32'd0);
    chk("abort_uf",   32'(uf_o),   32'd0);
    ndone = 0;
    repeat (W + 3) begin
      @(negedge clk_i);
      if (done_o) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    op(4'd4, 4'd4, "after_abort");
    @(negedge clk_i);

    // Reset wins over a simultaneous start
    rst_i   = 1'b1;
    start_i = 1'b1;
    x_i     = 4'd7;
    y_i     = 4'd2;
    @(negedge clk_i);
    rst_i   = 1'b0;
    start_i = 1'b0;
    chk("rst_prio_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    chk("rst_prio_idle", 32'(busy_o), 32'd0);

    // Exhaustive sweep of all operand pairs
    for (int x = 0; x < (1 << W); x++) begin
      for (int y = 0; y < (1 << W); y++) begin
        op(W'(x), W'(y), $sformatf("ex_%0d_%0d", x, y));
        @(negedge clk_i);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_u_serial.md
# sub_u_serial

Bit-serial unsigned subtractor with saturation at zero: computes x − y one bit per clock, LSB first, through a single borrow flip-flop. It is the inverse-direction companion of the unsigned saturating adder in the arithmetic examples. It trades area for latency behind a start/busy/done handshake. Downstream logic reads a registered difference and an underflow flag.

## Interface
- W, default 4: operand and result bit width, ≥ 2.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  request to begin a subtraction; honoured only while busy_o = 0.
- x_i  in  W  minuend, unsigned; sampled on the accepting edge only.
- y_i  in  W  subtrahend, unsigned; sampled on the accepting edge only.
- busy_o  out  1  high while an operation is in progress (state RUN).
- done_o  out  1  single-cycle pulse: diff_o and uf_o are valid and freshly updated.
- diff_o  out  W  result: x − y if x ≥ y, else 0 (saturated).
- uf_o  out  1  underflow flag: 1 when x < y.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_i = 1 loads x_i and y_i into shift registers, clears the borrow and the bit counter, and moves to RUN.
  - Otherwise stays in IDLE.
- RUN: each edge processes bit 0 of both shift registers:
  - d = x0 ^ y0 ^ b
  - b' = (~x0 & y0) | (~(x0 ^ y0) & b)
  - d shifts into the MSB of the result register; the operand registers shift right; the counter increments.
- At the edge that processes bit W−1:
  - Final borrow set: diff_o ← 0 and uf_o ← 1.
  - Otherwise: diff_o ← assembled result and uf_o ← 0.
  - done_o ← 1 and the FSM moves to DONE.
- DONE lasts exactly one cycle, then returns to IDLE.
  - busy_o = 0 in DONE, so start_i in DONE is accepted and goes straight to RUN (back-to-back).
- start_i during RUN is ignored and has no side effect. The operand registers are not reloaded.
- diff_o and uf_o hold their value until the next done_o pulse.
- x_i and y_i are don't-care outside the accepting edge.
- Counter width is $clog2(W). Arithmetic is modulo 2^W internally. Saturation is applied only at the final edge.

## Timing
- Reset values: busy_o = 0, done_o = 0, diff_o = 0, uf_o = 0, state IDLE, counter 0, borrow 0.
- Reset during RUN or DONE aborts the operation. No done_o follows, and outputs return to their reset values on that edge.
- Reset has priority over start_i on the same edge.
- Latency: start accepted at edge k → busy_o high from edge k through edge k+W−1. The final bit is processed at edge k+W, which sets done_o = 1 for the cycle after edge k+W.
- Throughput: one result per W+1 cycles with back-to-back starts.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package sub_u_pkg holds:
  - enum state_t {IDLE, RUN, DONE} (2-bit logic)
  - localparam function for counter width
- Sub-module full_sub_bit: combinational 1-bit full subtractor.
  - Inputs: x, y, b_in. Outputs: d, b_out.
  - Instantiated once in the datapath.
- Top module sub_u_serial holds the FSM, shift registers, counter, borrow flop, and the output registers.

## Test plan
- Basic: W=4, x=9, y=3, start one cycle → done_o exactly 4 cycles after the accepting edge; diff_o=6, uf_o=0, busy_o high for 4 cycles.
- Underflow: x=2, y=7 → diff_o=0, uf_o=1. Edges x=y=15 → diff_o=0, uf_o=0; x=15, y=0 → diff_o=15, uf_o=0; x=0, y=1 → diff_o=0, uf_o=1.
- Handshake:
  - Assert start_i with x=5, y=1 mid-RUN of x=12, y=4 → ignored; result diff_o=8.
  - Start in the DONE cycle → second result follows 5 cycles after the first done_o.
- Reset mid-operation: start x=10, y=3, pulse rst_i at the 2nd RUN cycle → no done_o, all outputs 0. A fresh start x=4, y=4 then completes with diff_o=0, uf_o=0.
- Exhaustive: all 256 (x, y) pairs for W=4 → diff_o = max(x−y, 0) and uf_o = (x<y), checked against the model at every done_o. Report pass/error counts and fail if the error count is nonzero.
